radix_digit_emitter: RTL and testbench
======================================

# radix_digit_emitter

Serial binary-to-text converter that renders the arithmetic results of the base-conversion exercises as printable digits. The block accepts one WIDTH-bit binary word and a radix selector: binary, quaternary, octal or hexadecimal. It emits the value as a fixed-width ASCII digit string, most-significant digit first, over a valid/ready stream. It sits between the arithmetic datapath, which produces the results, and the character sink (UART/console model), which displays them.

## Interface
- WIDTH, 8, bit width of the input word (2..32).
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_value/in_radix present.
- in_ready  out  1  block idle and able to accept a word.
- in_value  in  WIDTH  binary word to render.
- in_radix  in  2  00 binary, 01 quaternary, 10 octal, 11 hex.
- out_valid  out  1  out_char holds a digit.
- out_ready  in  1  sink accepts out_char.
- out_char  out  8  ASCII digit: '0'–'9' (0x30–0x39), 'A'–'F' (0x41–0x46).
- out_last  out  1  out_char is the final digit of the word.

## Operation
- Bits per digit (bpd): 1, 2, 3 or 4 for radix codes 00..11.
- Digit count: N = ceil(WIDTH/bpd). For WIDTH=8, N is 8, 4, 3 and 2 respectively.
- Leading zeros are always emitted; there is no zero suppression.
- The value is zero-extended on the left to N*bpd bits. The top digit is padded (e.g. octal top digit of an 8-bit value = {1'b0, in_value[7:6]}).
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch value (zero-extended, left-aligned in a shift register), radix and counter=N-1, then go to EMIT.
  - EMIT: present digit = top bpd bits of the shift register, converted to ASCII. On out_valid&&out_ready: if counter==0, go to IDLE; else shift left by bpd and decrement counter.
- out_last = (state==EMIT) && (counter==0).
- Hex digits are uppercase only.
- in_radix is sampled only at acceptance. Changes during EMIT are ignored.
- in_value and in_radix are don't-care when in_valid=0.

## Timing
- Reset values: out_valid=0, out_char=8'h00, out_last=0, in_ready=1, state=IDLE, counter=0.
- Latency: word accepted at edge k produces the first digit with out_valid=1 from edge k (registered), visible in cycle k+1.
- Throughput: one digit per cycle when out_ready=1. A word of N digits occupies N cycles of EMIT.
- One bubble between words: after the handshake on the last digit, in_ready=1 in the next cycle. No acceptance while in EMIT.
- Backpressure: while out_valid=1 and out_ready=0, out_char and out_last hold stable. out_valid never drops without a handshake.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-emission: all outputs go immediately (asynchronously) to their reset values and the partial string is discarded. After release, the first edge with in_valid=1 accepts a new word.
- in_radix values are all legal; there is no error path.

## Structure
- Shared package radix_pkg:
  - radix codes RADIX_BIN/QUAT/OCT/HEX.
  - ASCII_ZERO=8'h30 and ASCII_A=8'h41.
  - function bpd(radix) and function digit_count(radix, WIDTH).
- Sub-module digit_to_ascii: combinational 4-bit digit in, 8-bit ASCII out (0–9 → 0x30+d, 10–15 → 0x41+d-10).
- Main block: FSM, counter, shift register, output registers.

## Test plan
- Hex 0xC4, out_ready=1 → 'C'(0x43), '4'(0x34); out_last on second; in_ready high the cycle after.
- Quaternary 0xC4 → '3','0','1','0' on 4 consecutive cycles; out_last only on the fourth.
- Octal 0xC4 → '3','0','4'; binary 0x96 → "10010110", 8 digits, leading '1' first. Also binary 0x00 → eight '0', confirming no zero suppression.
- Backpressure: hex 0x5A with out_ready low 5 cycles on the first digit → '5' held stable with out_valid=1 for 5 cycles, then 'A', 'A' emitted exactly once.
- Reset mid-operation: quaternary 0xFF, assert rst_n=0 after second digit → out_valid=0, in_ready=1 immediately. After release, hex 0x3B → '3','B' with no residue from 0xFF.
- Radix change during EMIT: accept hex 0xC4, switch in_radix to 00 with in_valid=1 → still 'C','4'. The new word is accepted only after the last handshake.

Source files
------------

// File: rtl/radix_pkg.sv
// Shared radix codes, ASCII anchors and digit-geometry helpers for the
// digit emitter.
package radix_pkg;

   typedef enum logic [1:0] {
      RADIX_BIN  = 2'b00,
      RADIX_QUAT = 2'b01,
      RADIX_OCT  = 2'b10,
      RADIX_HEX  = 2'b11
   } radix_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } emit_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;

   function automatic int unsigned bpd(input radix_t radix);
      case (radix)
         RADIX_BIN:  return 1;
         RADIX_QUAT: return 2;
         RADIX_OCT:  return 3;
         default:    return 4;
      endcase
   endfunction

   function automatic int unsigned digit_count(input radix_t radix, input int unsigned width);
      return (width + bpd(radix) - 1) / bpd(radix);
   endfunction

endpackage

// File: rtl/digit_to_ascii.sv
// Combinational 4-bit digit to uppercase ASCII character.
module digit_to_ascii
   import radix_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] ascii
);

   always_comb begin
      if (digit < 4'd10) begin
         ascii = ASCII_ZERO + {4'b0000, digit};
      end else begin
         ascii = ASCII_A + {4'b0000, digit} - 8'd10;
      end
   end

endmodule

// File: rtl/radix_digit_emitter.sv
// Serial binary-to-ASCII converter: one WIDTH-bit word in, a fixed-width
// MSD-first digit string out over a valid/ready stream.
module radix_digit_emitter
   import radix_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   input  logic [1:0]       in_radix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last
);

   // Three spare bits cover the worst-case padding of the top digit.
   localparam int unsigned SW = WIDTH + 3;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   emit_state_t   state;
   radix_t        radix_q;
   logic [SW-1:0] sr;
   logic [CW-1:0] cnt;

   radix_t        sel_radix;
   int unsigned   sel_bpd;
   int unsigned   sel_n;
   int unsigned   pad;
   logic [SW-1:0] sr_nxt;
   logic [3:0]    top4;
   logic [3:0]    digit;
   logic [7:0]    ascii;

   // sr_nxt is the shift register as it will be after this edge, so the
   // character registered alongside it is always its top digit.
   always_comb begin
      sel_radix = (state == ST_IDLE) ? radix_t'(in_radix) : radix_q;
      sel_bpd   = bpd(sel_radix);
      sel_n     = digit_count(sel_radix, WIDTH);
      pad       = sel_n * sel_bpd - WIDTH;
      if (state == ST_IDLE) begin
         sr_nxt = {in_value, 3'b000} >> pad;
      end else begin
         sr_nxt = sr << sel_bpd;
      end
      top4  = sr_nxt[SW-1 -: 4];
      digit = top4 >> (4 - sel_bpd);
   end

   digit_to_ascii u_d2a (
      .digit (digit),
      .ascii (ascii)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         radix_q   <= RADIX_BIN;
         sr        <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_char  <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  state     <= ST_EMIT;
                  radix_q   <= sel_radix;
                  sr        <= sr_nxt;
                  cnt       <= CW'(sel_n - 1);
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  out_char  <= ascii;
                  out_last  <= (sel_n == 1);
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (cnt == '0) begin
                     state     <= ST_IDLE;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_char  <= '0;
                     out_last  <= 1'b0;
                  end else begin
                     sr       <= sr_nxt;
                     cnt      <= cnt - CW'(1);
                     out_char <= ascii;
                     out_last <= (cnt == CW'(1));
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_radix_digit_emitter.sv
// Directed bench for radix_digit_emitter: digit-string model checked every
// cycle, plus literal expected strings per test word.
module tb_radix_digit_emitter;

   localparam int unsigned WIDTH = 8;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_value  = '0;
   logic [1:0]       in_radix  = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_char;
   logic             out_last;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   bit         exp_last_q[$];
   logic [7:0] cap[$];
   bit         cap_last[$];

   bit         hold = 0;
   logic [7:0] hold_char;
   logic       hold_last;

   radix_digit_emitter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_radix  (in_radix),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Digit string of an accepted word, straight from positional notation.
   function automatic void model_accept(input int unsigned v, input int unsigned r);
      int unsigned b, n, d;
      b = r + 1;
      n = (WIDTH + b - 1) / b;
      for (int i = int'(n) - 1; i >= 0; i--) begin
         d = (v >> (i * int'(b))) & ((1 << b) - 1);
         exp_q.push_back(d < 10 ? 8'(32'h30 + d) : 8'(32'h41 + d - 10));
         exp_last_q.push_back(i == 0);
      end
   endfunction

   always @(negedge rst_n) begin
      exp_q.delete();
      exp_last_q.delete();
      hold = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         hold = 0;
      end else begin
         chk("out_valid_vs_model", out_valid, exp_q.size() != 0);
         chk("in_ready_vs_model", in_ready, exp_q.size() == 0);
         if (hold) begin
            chk("hold_char", out_char, hold_char);
            chk("hold_last", out_last, hold_last);
         end
         hold = 0;
         if (out_valid && exp_q.size() != 0) begin
            if (out_ready) begin
               chk("digit", out_char, exp_q[0]);
               chk("last", out_last, exp_last_q[0]);
               cap.push_back(out_char);
               cap_last.push_back(out_last);
               void'(exp_q.pop_front());
               void'(exp_last_q.pop_front());
            end else begin
               hold      = 1;
               hold_char = out_char;
               hold_last = out_last;
            end
         end
         if (in_valid && in_ready) model_accept(in_value, in_radix);
      end
   end

   task automatic send(input logic [7:0] v, input logic [1:0] r);
      bit ok = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = v;
      in_radix = r;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_value = ~v;
      in_radix = ~r;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout: got %0d pending digits, expected 0", exp_q.size());
      end
      @(negedge clk); #1;
   endtask

   task automatic check_str(input string name, input string s, input bit with_last);
      chk({name, "_len"}, cap.size(), s.len());
      for (int i = 0; i < s.len() && i < cap.size(); i++) begin
         chk(name, cap[i], s[i]);
         if (with_last) chk({name, "_lastflag"}, cap_last[i], i == s.len() - 1);
      end
   endtask

   task automatic run_word(input string name, input logic [7:0] v, input logic [1:0] r,
                           input string s);
      cap.delete();
      cap_last.delete();
      send(v, r);
      wait_idle();
      check_str(name, s, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_char", out_char, 8'h00);
      chk("reset_out_last", out_last, 0);
      chk("reset_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1 out_ready = 1'b1;

      run_word("hex_c4",  8'hC4, 2'b11, "C4");
      run_word("quat_c4", 8'hC4, 2'b01, "3010");
      run_word("oct_c4",  8'hC4, 2'b10, "304");
      run_word("bin_96",  8'h96, 2'b00, "10010110");
      run_word("bin_00",  8'h00, 2'b00, "00000000");
      run_word("hex_ff",  8'hFF, 2'b11, "FF");

      // Backpressure on the first digit
      cap.delete();
      cap_last.delete();
      @(posedge clk); #1 out_ready = 1'b0;
      send(8'h5A, 2'b11);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_char", out_char, 8'h35);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_idle();
      check_str("bp_5a", "5A", 1);

      // Reset in the middle of a quaternary word
      cap.delete();
      cap_last.delete();
      send(8'hFF, 2'b01);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (cap.size() >= 2) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         $display("FAIL rst_wait_timeout: got %0d digits, expected 2", cap.size());
      end
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_char", out_char, 8'h00);
      chk("midrst_out_last", out_last, 0);
      check_str("midrst_prefix", "33", 0);
      repeat (2) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      run_word("after_rst_3b", 8'h3B, 2'b11, "3B");

      // Radix change while emitting: next word waits for the last handshake
      cap.delete();
      cap_last.delete();
      send(8'hC4, 2'b11);
      send(8'h96, 2'b00);
      wait_idle();
      check_str("radix_change", "C410010110", 0);
      if (cap_last.size() == 10) begin
         chk("radix_change_last1", cap_last[1], 1);
         chk("radix_change_last0", cap_last[0], 0);
         chk("radix_change_last9", cap_last[9], 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
